// File: rtl/slvds_pkg.sv
// Shared constants and frame field offsets for the serial-LVDS test link.
package slvds_pkg;

  localparam int unsigned FRAME_LEN = 64;
  localparam int unsigned SYNC_W    = 2;
  localparam logic [1:0]  SYNC      = 2'b11;
  localparam logic        FLAG_DATA = 1'b1;
  localparam logic        FLAG_IDLE = 1'b0;

  // Channel id width: at least one bit even for a two-way link
  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch <= 2) ? 1 : unsigned'($clog2(nch));
  endfunction

  // Channel id starts right after the sync pattern
  function automatic int unsigned id_lsb();
    return SYNC_W;
  endfunction

  // Payload follows the channel id
  function automatic int unsigned data_lsb(input int unsigned ch_w);
    return SYNC_W + ch_w;
  endfunction

  // Data/idle flag follows the payload
  function automatic int unsigned flag_bit(input int unsigned ch_w, input int unsigned data_w);
    return SYNC_W + ch_w + data_w;
  endfunction

  // Even parity bit over id, payload and flag
  function automatic int unsigned par_bit(input int unsigned ch_w, input int unsigned data_w);
    return SYNC_W + ch_w + data_w + 1;
  endfunction

endpackage

// File: rtl/slvds_rr_arbiter.sv
// NCH-way round-robin arbiter; pointer advances past the winner only when enabled.
module slvds_rr_arbiter
  import slvds_pkg::*;
#(
  parameter int unsigned NCH = 4,
  localparam int unsigned CH_W = slvds_pkg::ch_width(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] idx,
  output logic            hit
);

  logic [CH_W-1:0] rr;

  // First requester at or after rr, else first requester from channel 0
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!hit && req[i] && (CH_W'(i) >= rr)) begin
        hit = 1'b1;
        idx = CH_W'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!hit && req[i]) begin
        hit = 1'b1;
        idx = CH_W'(i);
      end
    end
    gnt = (en && hit) ? (NCH'(1) << idx) : '0;
  end

  // Pointer moves to the channel after the winner on an enabled grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (en && hit) begin
      rr <= (32'(idx) == NCH - 1) ? '0 : idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/slvds_link_scheduler.sv
// Shares one serial test link between NCH requesters, one word per frame slot.
module slvds_link_scheduler #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = slvds_pkg::FRAME_LEN,
  localparam int unsigned CH_W     = slvds_pkg::ch_width(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH*DATA_W-1:0] req_data,
  output logic [NCH-1:0]        req_ready,
  input  logic                  idle_fill_en,
  output logic                  q,
  output logic                  frame_start,
  output logic [CH_W-1:0]       grant_id,
  output logic                  frame_is_data
);

  import slvds_pkg::*;

  localparam int unsigned CNT_W    = $clog2(FRAME_LEN);
  localparam int unsigned ID_LSB   = id_lsb();
  localparam int unsigned DATA_LSB = data_lsb(CH_W);
  localparam int unsigned FLAG_BIT = flag_bit(CH_W, DATA_W);
  localparam int unsigned PAR_BIT  = par_bit(CH_W, DATA_W);

  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] frame_c;
  logic [DATA_W-1:0]    idle_cnt;
  logic [DATA_W-1:0]    pay_c;
  logic [CH_W-1:0]      id_c;
  logic [CH_W-1:0]      arb_idx;
  logic [NCH-1:0]       arb_gnt;
  logic                 arb_hit;
  logic                 decide_c;
  logic                 send_c;
  logic                 flag_c;

  assign decide_c  = (cnt == '0) && !rst;
  assign req_ready = arb_gnt;

  slvds_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (decide_c),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .hit (arb_hit)
  );

  // Next frame image: granted word, idle counter word, or an all-zero empty slot
  always_comb begin
    frame_c = '0;
    id_c    = '0;
    pay_c   = '0;
    flag_c  = FLAG_IDLE;
    send_c  = 1'b0;
    if (arb_hit) begin
      id_c   = arb_idx;
      flag_c = FLAG_DATA;
      send_c = 1'b1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (arb_idx == CH_W'(i)) pay_c = req_data[i*DATA_W +: DATA_W];
      end
    end else if (idle_fill_en) begin
      pay_c  = idle_cnt;
      send_c = 1'b1;
    end
    if (send_c) begin
      frame_c[SYNC_W-1:0]          = SYNC;
      frame_c[ID_LSB +: CH_W]      = id_c;
      frame_c[DATA_LSB +: DATA_W]  = pay_c;
      frame_c[FLAG_BIT]            = flag_c;
      frame_c[PAR_BIT]             = ^{id_c, pay_c, flag_c};
    end
  end

  // Slot counter, frame load at the decision cycle, serial shift-out and idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      shreg         <= '0;
      q             <= 1'b0;
      frame_start   <= 1'b0;
      grant_id      <= '0;
      frame_is_data <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      cnt         <= (cnt == CNT_W'(FRAME_LEN - 1)) ? '0 : cnt + CNT_W'(1);
      frame_start <= 1'b0;
      if (cnt == '0) begin
        q             <= frame_c[0];
        shreg         <= frame_c >> 1;
        frame_start   <= send_c;
        frame_is_data <= arb_hit;
        if (arb_hit) begin
          grant_id <= arb_idx;
        end else if (idle_fill_en) begin
          idle_cnt <= idle_cnt + DATA_W'(1);
        end
      end else begin
        q     <= shreg[0];
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_slvds_link_scheduler.sv
// Self-checking bench: frame-level reference model of the shared serial link.
module tb_slvds_link_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int FL  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              idle_fill_en;
  logic              q;
  logic              frame_start;
  logic [1:0]        grant_id;
  logic              frame_is_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_rr;
  int m_idle;
  int m_gid;

  always #5 clk = ~clk;

  slvds_link_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .idle_fill_en  (idle_fill_en),
    .q             (q),
    .frame_start   (frame_start),
    .grant_id      (grant_id),
    .frame_is_data (frame_is_data)
  );

  // Expected 64-bit frame image, bit index = cycle within frame
  function automatic logic [63:0] exp_frame(input int id, input int pay, input bit flag);
    logic [63:0] f;
    int ones;
    f = 64'h3 | (64'(id & 3) << 2) | (64'(pay & 'hFFFF) << 4) | (64'(flag) << 20);
    ones = $countones(id & 3) + $countones(pay & 'hFFFF) + int'(flag);
    if ((ones % 2) == 1) f[21] = 1'b1;
    return f;
  endfunction

  // Slot decision of the model: round-robin grant, idle frame or empty slot
  task automatic model_decide(input logic [NCH-1:0] v, input logic ien, input logic [NCH*DW-1:0] data,
                              output logic [NCH-1:0] er, output logic [63:0] ef,
                              output logic efs, output logic edat, output logic [1:0] egid);
    int g;
    int c;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (m_rr + k) % NCH;
      if (g < 0 && ((v >> c) & 4'd1) != 0) g = c;
    end
    er = '0; ef = '0; efs = 1'b0; edat = 1'b0;
    if (g >= 0) begin
      er    = 4'(1 << g);
      ef    = exp_frame(g, int'(data[g*DW +: DW]), 1'b1);
      efs   = 1'b1;
      edat  = 1'b1;
      m_gid = g;
      m_rr  = (g + 1) % NCH;
    end else if (ien) begin
      ef     = exp_frame(0, m_idle, 1'b0);
      efs    = 1'b1;
      m_idle = (m_idle + 1) % 65536;
    end
    egid = 2'(m_gid);
  endtask

  // Observe one whole slot starting in a decision cycle; optionally change req_valid mid-slot
  task automatic capture_slot(input int chg_b, input logic [NCH-1:0] chg_v,
                              output logic [NCH-1:0] rdy0, output logic [63:0] bits,
                              output logic fs0, output logic [1:0] gid, output logic isd,
                              output logic fs_late, output logic rdy_late);
    #1;
    rdy0 = req_ready;
    bits = '0; fs_late = 1'b0; rdy_late = 1'b0; fs0 = 1'b0; gid = '0; isd = 1'b0;
    for (int b = 0; b < FL; b++) begin
      @(negedge clk);
      bits[b] = q;
      if (b == 0) begin
        fs0 = frame_start; gid = grant_id; isd = frame_is_data;
      end else begin
        fs_late = fs_late | frame_start;
      end
      if (b < FL - 1) rdy_late = rdy_late | (|req_ready);
      if (b == chg_b) req_valid = chg_v;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    m_rr = 0; m_idle = 0; m_gid = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; idle_fill_en = 1'b1; req_data = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    total++;
    if ({q, req_ready, frame_start, grant_id, frame_is_data} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs got q=%b rdy=%b fs=%b gid=%0d dat=%b want all 0", q, req_ready, frame_start, grant_id, frame_is_data);
    end
    m_rr = 0; m_idle = 0; m_gid = 0;
    rst = 1'b0;
  endtask

  task automatic test_empty();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    req_valid = '0; idle_fill_en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
      capture_slot(-1, '0, rdy, bits, fs0, gid, isd, fl, rl);
      total++;
      if ({rdy, rl} !== {er, 1'b0}) begin bad++; $display("FAIL empty[%0d] ready got=%b/%b want=%b/0", s, rdy, rl, er); end
      total++;
      if ({bits, fs0, fl, isd} !== {ef, efs, 1'b0, edat}) begin
        bad++; $display("FAIL empty[%0d] frame got=%h fs=%b/%b dat=%b want=%h fs=%b/0 dat=%b", s, bits, fs0, fl, isd, ef, efs, edat);
      end
    end
  endtask

  task automatic test_idle();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    req_valid = '0; idle_fill_en = 1'b1;
    for (int s = 0; s < 2; s++) begin
      model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
      capture_slot(-1, '0, rdy, bits, fs0, gid, isd, fl, rl);
      total++;
      if ({rdy, rl} !== {er, 1'b0}) begin bad++; $display("FAIL idle[%0d] ready got=%b/%b want=%b/0", s, rdy, rl, er); end
      total++;
      if ({bits, fs0, fl, gid, isd} !== {ef, efs, 1'b0, egid, edat}) begin
        bad++; $display("FAIL idle[%0d] frame got=%h fs=%b/%b gid=%0d dat=%b want=%h fs=%b/0 gid=%0d dat=%b", s, bits, fs0, fl, gid, isd, ef, efs, egid, edat);
      end
    end
  endtask

  task automatic test_single();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    req_data = {$urandom, $urandom};
    req_data[2*DW +: DW] = 16'hA5C3;
    req_valid = 4'b0100; idle_fill_en = 1'b1;
    model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
    capture_slot(0, '0, rdy, bits, fs0, gid, isd, fl, rl);
    total++;
    if ({rdy, rl} !== {4'b0100, 1'b0}) begin bad++; $display("FAIL single ready got=%b/%b want=0100/0", rdy, rl); end
    total++;
    if ({bits, fs0, fl, gid, isd} !== {ef, efs, 1'b0, egid, edat}) begin
      bad++; $display("FAIL single frame got=%h fs=%b/%b gid=%0d dat=%b want=%h fs=%b/0 gid=%0d dat=%b", bits, fs0, fl, gid, isd, ef, efs, egid, edat);
    end
  endtask

  task automatic test_all_valid();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    do_reset();
    req_valid = 4'hF; idle_fill_en = 1'b0; req_data = {$urandom, $urandom};
    for (int s = 0; s < 5; s++) begin
      model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
      capture_slot(-1, '0, rdy, bits, fs0, gid, isd, fl, rl);
      total++;
      if ({rdy, rl} !== {er, 1'b0}) begin bad++; $display("FAIL allvalid[%0d] ready got=%b/%b want=%b/0", s, rdy, rl, er); end
      total++;
      if ({bits, fs0, fl, gid, isd} !== {ef, efs, 1'b0, egid, edat}) begin
        bad++; $display("FAIL allvalid[%0d] frame got=%h fs=%b/%b gid=%0d dat=%b want=%h fs=%b/0 gid=%0d dat=%b", s, bits, fs0, fl, gid, isd, ef, efs, egid, edat);
      end
    end
  endtask

  task automatic test_late_req();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    req_valid = '0; idle_fill_en = 1'($urandom);
    for (int s = 0; s < 2; s++) begin
      model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
      if (s == 0) capture_slot(4, 4'b0010, rdy, bits, fs0, gid, isd, fl, rl);
      else        capture_slot(0, 4'b0000, rdy, bits, fs0, gid, isd, fl, rl);
      total++;
      if ({rdy, rl} !== {er, 1'b0}) begin bad++; $display("FAIL late[%0d] ready got=%b/%b want=%b/0", s, rdy, rl, er); end
      total++;
      if ({bits, fs0, fl, gid, isd} !== {ef, efs, 1'b0, egid, edat}) begin
        bad++; $display("FAIL late[%0d] frame got=%h fs=%b/%b gid=%0d dat=%b want=%h fs=%b/0 gid=%0d dat=%b", s, bits, fs0, fl, gid, isd, ef, efs, egid, edat);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    do_reset();
    req_valid = '0; idle_fill_en = 1'b1; req_data = {$urandom, $urandom};
    // one idle frame so the idle counter is non-zero before the reset
    model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
    capture_slot(-1, '0, rdy, bits, fs0, gid, isd, fl, rl);
    total++;
    if ({bits, fs0} !== {ef, efs}) begin bad++; $display("FAIL midrst_pre frame got=%h fs=%b want=%h fs=%b", bits, fs0, ef, efs); end
    // ch3 data frame, aborted at cnt==10
    req_valid = 4'b1000;
    model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
    #1;
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL midrst_ready got=%b want=1000", req_ready); end
    bits = '0;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      bits[b] = q;
    end
    rst = 1'b1;
    req_valid = 4'b1011;
    total++;
    if (bits[9:0] !== ef[9:0]) begin bad++; $display("FAIL midrst_partial got=%b want=%b", bits[9:0], ef[9:0]); end
    @(negedge clk);
    total++;
    if ({q, frame_start, grant_id, frame_is_data, req_ready} !== 9'b0) begin
      bad++; $display("FAIL midrst_abort got q=%b fs=%b gid=%0d dat=%b rdy=%b want all 0", q, frame_start, grant_id, frame_is_data, req_ready);
    end
    rst = 1'b0;
    m_rr = 0; m_idle = 0; m_gid = 0;
    for (int s = 0; s < 2; s++) begin
      model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
      capture_slot(0, '0, rdy, bits, fs0, gid, isd, fl, rl);
      total++;
      if ({rdy, rl} !== {er, 1'b0}) begin bad++; $display("FAIL midrst_after[%0d] ready got=%b/%b want=%b/0", s, rdy, rl, er); end
      total++;
      if ({bits, fs0, fl, gid, isd} !== {ef, efs, 1'b0, egid, edat}) begin
        bad++; $display("FAIL midrst_after[%0d] frame got=%h fs=%b/%b gid=%0d dat=%b want=%h fs=%b/0 gid=%0d dat=%b", s, bits, fs0, fl, gid, isd, ef, efs, egid, edat);
      end
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] er, rdy; logic [63:0] ef, bits; logic efs, edat, fs0, isd, fl, rl; logic [1:0] egid, gid;
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 1) == 1) req_valid = 4'($urandom);
      idle_fill_en = 1'($urandom);
      req_data = {$urandom, $urandom};
      model_decide(req_valid, idle_fill_en, req_data, er, ef, efs, edat, egid);
      capture_slot($urandom_range(0, FL - 2), 4'($urandom), rdy, bits, fs0, gid, isd, fl, rl);
      total++;
      if ({rdy, rl} !== {er, 1'b0}) begin bad++; $display("FAIL random[%0d] ready got=%b/%b want=%b/0", s, rdy, rl, er); end
      total++;
      if ({bits, fs0, fl, gid, isd} !== {ef, efs, 1'b0, egid, edat}) begin
        bad++; $display("FAIL random[%0d] frame got=%h fs=%b/%b gid=%0d dat=%b want=%h fs=%b/0 gid=%0d dat=%b", s, bits, fs0, fl, gid, isd, ef, efs, egid, edat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_idle();
    test_single();
    test_all_valid();
    test_late_req();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

endmodule

// File: doc/slvds_link_scheduler.md
# slvds_link_scheduler

Shares one serial-LVDS test link between `NCH` requesters. Each 64-cycle frame slot carries one 16-bit word, chosen by round-robin arbitration at the slot boundary, and shifts it out LSB first behind a `11` sync pattern. When no requester is pending, the slot carries an optional idle test-counter frame. The block sits between on-board data sources and the single-ended serial output pin, and replaces the free-running test serializer as the owner of the link.

## Interface
- `NCH`, 4: number of requesters, 2..16.
- `DATA_W`, 16: payload width.
- `FRAME_LEN`, 64: cycles per slot; must be ≥ `DATA_W + CH_W + 4`, where `CH_W = max(1, clog2(NCH))`.
- `clk`  in  1: link bit clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NCH: per-channel word pending.
- `req_data`  in  NCH*DATA_W: channel i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NCH: one-hot accept strobe.
- `idle_fill_en`  in  1: send counter frames in empty slots.
- `q`  out  1: serial line, registered.
- `frame_start`  out  1: high while frame bit 0 is on `q`.
- `grant_id`  out  CH_W: channel of the last data frame.
- `frame_is_data`  out  1: current frame carries requester data.

## Operation
- Slot counter `cnt` runs 0..FRAME_LEN-1 and wraps. The decision cycle is `cnt==0`.
- In the decision cycle the arbiter samples `req_valid`.
  - It grants the first valid channel at or after pointer `rr`.
  - `req_ready[g]` is high combinationally in that cycle only, so transfer = valid & ready at `cnt==0`.
  - `req_data[g]` is latched, and `rr` becomes `g+1` mod NCH.
- Frame bit layout (index = cycle within frame):
  - bits 0–1: `1,1`.
  - next CH_W bits: channel id, LSB first.
  - next DATA_W bits: payload, LSB first.
  - next bit: flag (1 = data, 0 = idle).
  - next bit: even parity over id, payload and flag.
  - remaining bits: 0.
  - Defaults: id at bits 2–3, data at 4–19, flag at 20, parity at 21, zeros at 22–63.
- No valid channel and `idle_fill_en=1`: send an idle frame with id 0, payload = 16-bit idle counter, flag 0. The counter increments after each idle frame and wraps 0xFFFF→0.
- No valid channel and `idle_fill_en=0`: `q` stays 0 for the whole slot, with no sync bits, no `frame_start` and no counter change.
- `req_valid` changes outside `cnt==0` are ignored until the next decision cycle.
- Simultaneous requests are resolved by round-robin order only; there is no starvation beyond NCH-1 slots.

## Timing
- Reset values:
  - `q`=0, `req_ready`=0, `frame_start`=0, `grant_id`=0, `frame_is_data`=0.
  - `cnt`=0, `rr`=0, idle counter 0.
- The first decision cycle is the first cycle with `rst` low.
- Latency: frame bit b is on `q` in the cycle where `cnt==b+1`, wrapping. Bit FRAME_LEN-1 coincides with the next decision cycle.
- `frame_start`, `grant_id` and `frame_is_data` update in the same cycle as bit 0.
- Reset mid-frame:
  - `q` is 0 in the cycle after `rst` is sampled high, and the frame is aborted.
  - A word already accepted is discarded.
  - Arbitration restarts at ch0.
- Throughput: at most one word per FRAME_LEN cycles for the whole link.

## Structure
- Shared package `slvds_pkg` holds:
  - `FRAME_LEN`, the sync pattern `2'b11`, and the flag encodings.
  - Field-offset functions `id_lsb()`, `data_lsb()`, `flag_bit()`, `par_bit()` of `CH_W`/`DATA_W`, also used by the future receiver.
- Sub-module `slvds_rr_arbiter`: parameterised NCH-way round-robin, with request vector and enable in, one-hot grant and index out. Its pointer update is gated by enable.
- Top level holds the slot counter, the frame shift register (loaded at `cnt==0`) and the idle counter.

## Test plan
- Reset, no valid, `idle_fill_en=0`, 128 cycles -> `q` constantly 0, `req_ready` never high, `frame_start` never high.
- `idle_fill_en=1`, no valid -> frame 1: `11`,`00`, payload 0x0000, flag 0, parity 0. Frame 2: payload 0x0001, parity 1. Frames start 64 cycles apart.
- `req_valid[2]`=1 with `req_data` ch2 = 0xA5C3 -> `req_ready`=4'b0100 at `cnt==0`. Frame: `11`, id bits `0,1`, payload LSB first `1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1`, flag 1, parity 0. `grant_id`=2.
- All four channels held valid -> grants 0,1,2,3,0 in consecutive slots, exactly one ready pulse each.
- `req_valid[1]` raised at `cnt==5` -> no ready until the next `cnt==0`. The current slot is an idle or empty frame.
- `rst` pulsed at `cnt==10` of a ch3 data frame -> `q`=0 the next cycle. A new decision occurs the cycle `rst` falls, with ch0 highest priority and the idle counter at 0.
